// File: rtl/sd_cmd_control_pkg.sv
// Shared definitions for the SD CMD line path: state encoding and frame geometry,
// also imported by the command receive shift register.
package sd_cmd_control_pkg;

    typedef enum logic [2:0] {
        CMD_STATE_IDLE    = 3'd0,
        CMD_STATE_SEND    = 3'd1,
        CMD_STATE_WAIT    = 3'd2,
        CMD_STATE_RECEIVE = 3'd3,
        CMD_STATE_FINISH  = 3'd4
    } cmd_state_t;

    localparam int CMD_FRAME_BITS = 48;
    localparam int CMD_CRC_FIRST  = 40;
    localparam int CMD_END_BIT    = CMD_FRAME_BITS - 1;
    localparam int RESP_END_SHORT = 46;
    localparam int RESP_END_LONG  = 134;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1), zero seed, one message bit per enabled clock.
module sd_crc7 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [6:0] crc
);

    logic feedback;

    assign feedback = crc[6] ^ bit_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= 7'd0;
        end else if (clear) begin
            crc <= 7'd0;
        end else if (enable) begin
            crc <= {crc[5:3], crc[2] ^ feedback, crc[1:0], feedback};
        end
    end

endmodule

// File: rtl/sd_cmd_control.sv
// SD CMD line controller: serialises the 48-bit command frame with CRC7, then waits
// for and times the card response. All outputs are registered.
module sd_cmd_control #(
    parameter int NCR_MAX    = 64,
    parameter int NCC_CYCLES = 8
) (
    input  logic        in_sd_clk,
    input  logic        hrst_n,
    input  logic        in_soft_reset,
    input  logic        in_command_start,
    input  logic [5:0]  in_command_index,
    input  logic [31:0] in_command_argument,
    input  logic        in_has_response,
    input  logic        in_long_response,
    input  logic        in_serial_cmd,
    output logic        out_sd_cmd,
    output logic        out_sd_cmd_oe,
    output logic [2:0]  out_current_state,
    output logic [7:0]  out_has_receive_bit,
    output logic        out_cmd_complete,
    output logic        out_cmd_timeout_error
);
    import sd_cmd_control_pkg::*;

    localparam logic [15:0] WAIT_LAST   = 16'(NCR_MAX - 1);
    localparam logic [7:0]  FINISH_LAST = 8'(NCC_CYCLES - 1);

    cmd_state_t  state, state_n;
    logic [5:0]  send_cnt, send_cnt_n;
    logic [15:0] wait_cnt, wait_cnt_n;
    logic [7:0]  finish_cnt, finish_cnt_n;
    logic [7:0]  recv_cnt, recv_cnt_n;
    logic [39:0] payload, payload_n;
    logic        has_resp, has_resp_n;
    logic        long_resp, long_resp_n;
    logic        sd_cmd_n, oe_n, complete_n, timeout_n;
    logic        crc_clear, crc_enable;
    logic [6:0]  crc;
    logic [7:0]  crc_ext;
    logic [2:0]  crc_sel;
    logic [7:0]  recv_end;

    // The CRC is fed one bit ahead of the line so its final value is ready at bit 40.
    sd_crc7 u_crc7 (
        .clk    (in_sd_clk),
        .rst_n  (hrst_n),
        .clear  (crc_clear),
        .enable (crc_enable),
        .bit_in (payload[38]),
        .crc    (crc)
    );

    assign crc_ext  = {1'b0, crc};
    assign crc_sel  = 3'(6'(CMD_END_BIT - 2) - send_cnt);
    assign recv_end = long_resp ? 8'(RESP_END_LONG) : 8'(RESP_END_SHORT);

    assign crc_clear  = !in_soft_reset || (state == CMD_STATE_IDLE && in_command_start);
    assign crc_enable = (state == CMD_STATE_SEND) && (send_cnt < 6'(CMD_CRC_FIRST - 1));

    always_comb begin
        state_n      = state;
        send_cnt_n   = send_cnt;
        wait_cnt_n   = wait_cnt;
        finish_cnt_n = finish_cnt;
        recv_cnt_n   = recv_cnt;
        payload_n    = payload;
        has_resp_n   = has_resp;
        long_resp_n  = long_resp;
        sd_cmd_n     = 1'b1;
        oe_n         = 1'b0;
        complete_n   = 1'b0;
        timeout_n    = out_cmd_timeout_error;

        case (state)
            CMD_STATE_IDLE: begin
                if (in_command_start) begin
                    state_n     = CMD_STATE_SEND;
                    payload_n   = {2'b01, in_command_index, in_command_argument};
                    has_resp_n  = in_has_response;
                    long_resp_n = in_long_response;
                    send_cnt_n  = 6'd0;
                    wait_cnt_n  = 16'd0;
                    recv_cnt_n  = 8'd0;
                    timeout_n   = 1'b0;
                    sd_cmd_n    = 1'b0;
                    oe_n        = 1'b1;
                end
            end
            // Each edge loads the line with the bit for the following send_cnt.
            CMD_STATE_SEND: begin
                oe_n       = 1'b1;
                send_cnt_n = send_cnt + 6'd1;
                payload_n  = payload << 1;
                if (send_cnt < 6'(CMD_CRC_FIRST - 1)) begin
                    sd_cmd_n = payload[38];
                end else if (send_cnt < 6'(CMD_END_BIT - 1)) begin
                    sd_cmd_n = crc_ext[crc_sel];
                end else if (send_cnt == 6'(CMD_END_BIT)) begin
                    oe_n         = 1'b0;
                    wait_cnt_n   = 16'd0;
                    finish_cnt_n = 8'd0;
                    state_n      = has_resp ? CMD_STATE_WAIT : CMD_STATE_FINISH;
                end
            end
            CMD_STATE_WAIT: begin
                wait_cnt_n = wait_cnt + 16'd1;
                if (!in_serial_cmd) begin
                    state_n    = CMD_STATE_RECEIVE;
                    recv_cnt_n = 8'd0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n      = CMD_STATE_FINISH;
                    finish_cnt_n = 8'd0;
                    timeout_n    = 1'b1;
                end
            end
            CMD_STATE_RECEIVE: begin
                if (recv_cnt == recv_end) begin
                    state_n      = CMD_STATE_FINISH;
                    finish_cnt_n = 8'd0;
                end else if (recv_cnt != 8'hFF) begin
                    recv_cnt_n = recv_cnt + 8'd1;
                end
            end
            CMD_STATE_FINISH: begin
                if (finish_cnt == FINISH_LAST) begin
                    state_n    = CMD_STATE_IDLE;
                    complete_n = 1'b1;
                end else begin
                    finish_cnt_n = finish_cnt + 8'd1;
                end
            end
            default: state_n = CMD_STATE_IDLE;
        endcase

        if (!in_soft_reset) begin
            state_n      = CMD_STATE_IDLE;
            send_cnt_n   = 6'd0;
            wait_cnt_n   = 16'd0;
            finish_cnt_n = 8'd0;
            recv_cnt_n   = 8'd0;
            sd_cmd_n     = 1'b1;
            oe_n         = 1'b0;
            complete_n   = 1'b0;
            timeout_n    = 1'b0;
        end
    end

    always_ff @(posedge in_sd_clk or negedge hrst_n) begin
        if (!hrst_n) begin
            state                 <= CMD_STATE_IDLE;
            send_cnt              <= 6'd0;
            wait_cnt              <= 16'd0;
            finish_cnt            <= 8'd0;
            recv_cnt              <= 8'd0;
            payload               <= 40'd0;
            has_resp              <= 1'b0;
            long_resp             <= 1'b0;
            out_sd_cmd            <= 1'b1;
            out_sd_cmd_oe         <= 1'b0;
            out_cmd_complete      <= 1'b0;
            out_cmd_timeout_error <= 1'b0;
        end else begin
            state                 <= state_n;
            send_cnt              <= send_cnt_n;
            wait_cnt              <= wait_cnt_n;
            finish_cnt            <= finish_cnt_n;
            recv_cnt              <= recv_cnt_n;
            payload               <= payload_n;
            has_resp              <= has_resp_n;
            long_resp             <= long_resp_n;
            out_sd_cmd            <= sd_cmd_n;
            out_sd_cmd_oe         <= oe_n;
            out_cmd_complete      <= complete_n;
            out_cmd_timeout_error <= timeout_n;
        end
    end

    assign out_current_state   = state;
    assign out_has_receive_bit = recv_cnt;

endmodule

// File: tb/tb_sd_cmd_control.sv
// Bench for sd_cmd_control: a per-command expected trace is built from the frame
// and response rules, then checked cycle by cycle against the DUT outputs.
module tb_sd_cmd_control;

    logic        clk = 1'b0;
    logic        hrst_n;
    logic        soft_reset;
    logic        command_start;
    logic [5:0]  command_index;
    logic [31:0] command_argument;
    logic        has_response;
    logic        long_response;
    logic        serial_cmd;
    logic        sd_cmd;
    logic        sd_cmd_oe;
    logic [2:0]  current_state;
    logic [7:0]  has_receive_bit;
    logic        cmd_complete;
    logic        cmd_timeout_error;

    typedef struct {
        logic [2:0] st;
        logic       cmd;
        logic       oe;
        logic [7:0] rcv;
        logic       cmp;
        logic       tmo;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [47:0] cap_frame = 48'd0;
    int          oe_cycles = 0;
    logic        prev_oe = 1'b0;
    logic [7:0]  m_rcv;
    logic        m_timeout;

    always #5 clk = ~clk;

    sd_cmd_control #(.NCR_MAX(64), .NCC_CYCLES(8)) dut (
        .in_sd_clk             (clk),
        .hrst_n                (hrst_n),
        .in_soft_reset         (soft_reset),
        .in_command_start      (command_start),
        .in_command_index      (command_index),
        .in_command_argument   (command_argument),
        .in_has_response       (has_response),
        .in_long_response      (long_response),
        .in_serial_cmd         (serial_cmd),
        .out_sd_cmd            (sd_cmd),
        .out_sd_cmd_oe         (sd_cmd_oe),
        .out_current_state     (current_state),
        .out_has_receive_bit   (has_receive_bit),
        .out_cmd_complete      (cmd_complete),
        .out_cmd_timeout_error (cmd_timeout_error)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] model_crc7(input logic [39:0] msg);
        logic [46:0] rem;
        rem = {msg, 7'd0};
        for (int i = 46; i >= 7; i--)
            if (rem[i]) rem[i -: 8] = rem[i -: 8] ^ 8'h89;
        return rem[6:0];
    endfunction

    function automatic logic [47:0] model_frame(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] msg;
        msg = {2'b01, idx, arg};
        return {msg, model_crc7(msg), 1'b1};
    endfunction

    task automatic push(input logic [2:0] st, input logic cmd, input logic oe,
                        input logic [7:0] rcv, input logic cmp, input logic tmo);
        exp_t e;
        e.st = st; e.cmd = cmd; e.oe = oe; e.rcv = rcv; e.cmp = cmp; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    // Single compare process: one expected entry per cycle while a trace is pending.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("state",    current_state,     e.st);
            checkOutput("sd_cmd",   sd_cmd,            e.cmd);
            checkOutput("oe",       sd_cmd_oe,         e.oe);
            checkOutput("rcv_bit",  has_receive_bit,   e.rcv);
            checkOutput("complete", cmd_complete,      e.cmp);
            checkOutput("timeout",  cmd_timeout_error, e.tmo);
        end
    end

    always @(negedge clk) begin
        if (sd_cmd_oe && !prev_oe) begin
            cap_frame = {47'd0, sd_cmd};
            oe_cycles = 1;
        end else if (sd_cmd_oe) begin
            cap_frame = {cap_frame[46:0], sd_cmd};
            oe_cycles++;
        end
        prev_oe = sd_cmd_oe;
    end

    // gap: cycles after the end bit until the card start bit (<=0: card never answers).
    // abort_at: send_cnt at which soft reset is pulsed (<0: none).
    task automatic applyStimulus(input string name, input logic [5:0] idx, input logic [31:0] arg,
                                 input logic has, input logic lng, input int gap, input int abort_at,
                                 input logic inject, input logic [47:0] lit_frame);
        logic [47:0] fr;
        int n_send;
        int len;
        int endr;
        @(posedge clk); #1;
        command_index    = idx;
        command_argument = arg;
        has_response     = has;
        long_response    = lng;
        command_start    = 1'b1;
        @(posedge clk); #1;
        command_start = 1'b0;

        fr        = model_frame(idx, arg);
        m_rcv     = 8'd0;
        m_timeout = 1'b0;
        n_send    = (abort_at >= 0) ? abort_at + 1 : 48;
        for (int k = 0; k < n_send; k++) push(3'd1, fr[47 - k], 1'b1, 8'd0, 1'b0, 1'b0);
        if (abort_at >= 0) begin
            for (int k = 0; k < 10; k++) push(3'd0, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        end else begin
            if (has) begin
                if (gap > 0) begin
                    endr = lng ? 134 : 46;
                    for (int k = 0; k < gap; k++) push(3'd2, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
                    for (int r = 0; r <= endr; r++) push(3'd3, 1'b1, 1'b0, 8'(r), 1'b0, 1'b0);
                    m_rcv = 8'(endr);
                end else begin
                    for (int k = 0; k < 64; k++) push(3'd2, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
                    m_timeout = 1'b1;
                end
            end
            for (int k = 0; k < 8; k++) push(3'd4, 1'b1, 1'b0, m_rcv, 1'b0, m_timeout);
            push(3'd0, 1'b1, 1'b0, m_rcv, 1'b1, m_timeout);
            push(3'd0, 1'b1, 1'b0, m_rcv, 1'b0, m_timeout);
            push(3'd0, 1'b1, 1'b0, m_rcv, 1'b0, m_timeout);
        end

        len = exp_q.size();
        for (int k = 1; k <= len; k++) begin
            serial_cmd    = (has && gap > 0 && k == 48 + gap) ? 1'b0 : 1'b1;
            command_start = inject && (k == 50);
            if (inject && k == 50) command_index = 6'h11;
            soft_reset    = !(abort_at >= 0 && k == abort_at + 1);
            @(posedge clk); #1;
        end
        serial_cmd    = 1'b1;
        command_start = 1'b0;
        soft_reset    = 1'b1;

        checkOutput({name, "_trace_drained"}, exp_q.size(), 0);
        checkOutput({name, "_model_frame"}, fr, lit_frame);
        checkOutput({name, "_oe_cycles"}, oe_cycles, n_send);
        if (abort_at < 0) checkOutput({name, "_line_frame"}, cap_frame, lit_frame);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        hrst_n           = 1'b0;
        soft_reset       = 1'b1;
        command_start    = 1'b0;
        command_index    = 6'd0;
        command_argument = 32'd0;
        has_response     = 1'b0;
        long_response    = 1'b0;
        serial_cmd       = 1'b1;
        #12;
        checkOutput("reset_state",    current_state,     3'd0);
        checkOutput("reset_sd_cmd",   sd_cmd,            1'b1);
        checkOutput("reset_oe",       sd_cmd_oe,         1'b0);
        checkOutput("reset_rcv",      has_receive_bit,   8'd0);
        checkOutput("reset_complete", cmd_complete,      1'b0);
        checkOutput("reset_timeout",  cmd_timeout_error, 1'b0);
        checkOutput("crc_cmd17", model_crc7(40'h5100000000), 7'h2A);
        #10;
        hrst_n = 1'b1;

        applyStimulus("cmd0",       6'd0,  32'h0,        1'b0, 1'b0, 0,  -1, 1'b0, 48'h400000000095);
        applyStimulus("cmd8",       6'd8,  32'h000001AA, 1'b1, 1'b0, 5,  -1, 1'b1, 48'h48000001AA87);
        applyStimulus("cmd17_long", 6'd17, 32'h0,        1'b1, 1'b1, 3,  -1, 1'b0, 48'h510000000055);
        applyStimulus("cmd2_tmo",   6'd2,  32'h0,        1'b1, 1'b0, 0,  -1, 1'b0, 48'h42000000004D);
        applyStimulus("cmd0_again", 6'd0,  32'h0,        1'b0, 1'b0, 0,  -1, 1'b0, 48'h400000000095);
        applyStimulus("cmd55_last", 6'd55, 32'h0,        1'b1, 1'b0, 64, -1, 1'b0, 48'h770000000065);
        applyStimulus("soft_abort", 6'd17, 32'h0,        1'b0, 1'b0, 0,  20, 1'b0, 48'h510000000055);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
